mem_arbiter_rr2: RTL
====================

Name: mem_arbiter_rr2

Overview:
Two-master round-robin arbiter for the picorv32 native memory interface (valid/ready, addr, wdata, wstrb, rdata, instr). It shares one memory/peripheral slave port between two requesters, for example the CPU core and a DMA engine or a second core. The arbiter holds a grant for exactly one transaction. It adds a per-transaction watchdog that aborts a hung slave access.

Parameters:
TIMEOUT, 255, max cycles a granted transaction may wait for slave ready; 0 disables the watchdog.
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned to the master on an aborted transaction.

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
m0_mem_valid  input  1  master 0 request; held with its signals stable until m0_mem_ready
m0_mem_instr  input  1  master 0 instruction-fetch flag
m0_mem_addr  input  32  master 0 byte address
m0_mem_wdata  input  32  master 0 write data
m0_mem_wstrb  input  4  master 0 byte strobes; 0 means read
m0_mem_ready  output  1  master 0 completion strobe
m0_mem_rdata  output  32  master 0 read data
m1_*  same seven signals as m0_*, for master 1
mem_valid  output  1  slave request
mem_instr  output  1  slave instr flag
mem_addr  output  32  slave address
mem_wdata  output  32  slave write data
mem_wstrb  output  4  slave strobes
mem_ready  input  1  slave completion
mem_rdata  input  32  slave read data
grant  output  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle
timeout_err  output  1  sticky; set by any watchdog abort

Behaviour:
- Registered state: IDLE, OWN0, OWN1. Also a last-served pointer `last`, a watchdog counter `wd` of width $clog2(TIMEOUT+1), and `timeout_err`.
- Reset (resetn = 0 at clk edge):
  - state = IDLE, last = 1 (so m0 wins the first tie), wd = 0, timeout_err = 0.
  - All outputs are 0 combinationally while in IDLE.
  - An in-flight transaction is dropped: mem_valid falls the cycle after the reset edge, and no ready is issued to any master.
- IDLE transitions:
  - only m0 valid -> OWN0.
  - only m1 valid -> OWN1.
  - both valid -> the master other than `last`.
  - none -> stay in IDLE.
  - The grant takes effect the next cycle. Minimum request-to-mem_valid latency is 1 cycle.
- OWNx datapath:
  - mem_valid = mx_mem_valid & ~abort.
  - mem_instr, mem_addr, mem_wdata and mem_wstrb are combinationally muxed from master x.
  - mx_mem_ready = mem_ready | abort.
  - mx_mem_rdata = abort ? TIMEOUT_RDATA : mem_rdata.
  - The non-granted master sees ready = 0 and rdata = 0.
  - In IDLE, the slave-side outputs are 0.
- Completion cycle (mem_ready = 1 or abort = 1 while OWNx):
  - `last` is set to x and wd is cleared.
  - If the other master is valid, go directly to OWN(other) with no bubble. Otherwise go to IDLE.
  - Master x's own valid is ignored in this decision, because a picorv32 master drops valid after ready.
- Granted master drops valid without a ready (protocol violation): return to IDLE next cycle, `last` unchanged, no ready issued.
- Watchdog:
  - wd increments each OWNx cycle without mem_ready and saturates at TIMEOUT.
  - abort = (TIMEOUT != 0) & (wd == TIMEOUT) & ~mem_ready.
  - mem_ready arriving in the abort cycle takes priority: normal completion, no error.
  - An abort sets timeout_err, which stays 1 until reset.
  - TIMEOUT = 0: abort is never asserted and wd stays 0.
- mem_ready while IDLE is ignored.
- Throughput: under continuous contention, each master gets every other transaction, back-to-back.

Test Plan:
- Single master: m0 reads addr 0x100, slave ready 2 cycles after mem_valid rises with rdata 0x12345678 -> grant = 01 one cycle after m0_mem_valid; m0_mem_rdata = 0x12345678 with m0_mem_ready for 1 cycle; then grant = 00; m1_mem_ready never asserted.
- Simultaneous first request: m0 and m1 assert valid in the same cycle after reset -> m0 is served first. m1 is granted in the cycle immediately after m0's ready (grant 01 -> 10, no idle cycle). m1 write wstrb = 4'b0011, wdata = 0xA5A5_5A5A appears on the slave unchanged.
- Sustained contention: both masters reissue after every ready, 8 transactions total -> grant alternates 01, 10, 01, ...; each master gets 4 completions; no starvation.
- Watchdog, TIMEOUT = 4: slave never readies an m1 read -> after 4 waiting cycles m1_mem_ready = 1 with m1_mem_rdata = 0xDEAD_BEEF. mem_valid = 0 in that cycle; timeout_err = 1 and stays 1 through later good transactions.
- Ready at the limit, TIMEOUT = 4: mem_ready arrives exactly in the would-be abort cycle -> normal slave rdata is returned; timeout_err stays 0.
- Reset mid-transaction: resetn = 0 while OWN0 is waiting -> the next cycle has grant = 00, mem_valid = 0, and no ready to either master. After resetn returns high with both masters requesting, m0 is granted first.

Source files
------------

// File: rtl/mem_arbiter_rr2.sv
// mem_arbiter_rr2: two-master round-robin arbiter for the picorv32 native memory bus with a per-transaction watchdog
module mem_arbiter_rr2 #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);
  localparam int WDW = TIMEOUT == 0 ? 1 : $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_n;
  logic last, last_n;
  logic [WDW-1:0] wd, wd_n;
  logic own0, own1, cur_valid, other_valid, abort, done;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign cur_valid = (own0 & m0_mem_valid) | (own1 & m1_mem_valid);
  assign other_valid = (own0 & m1_mem_valid) | (own1 & m0_mem_valid);
  assign abort = (TIMEOUT != 0) && cur_valid && wd == WDW'(TIMEOUT) && !mem_ready;
  assign done = cur_valid & (mem_ready | abort);
  // state, round-robin pointer, watchdog and sticky error registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      last <= 1'b1;
      wd <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      last <= last_n;
      wd <= wd_n;
      timeout_err <= timeout_err | abort;
    end
  end
  // next owner: tie goes to the master not served last; hand over without a bubble on completion
  always_comb begin
    state_n = state;
    last_n = last;
    wd_n = '0;
    if (state == IDLE)
      state_n = (m0_mem_valid & m1_mem_valid) ? (last ? OWN0 : OWN1) :
                m0_mem_valid ? OWN0 : m1_mem_valid ? OWN1 : IDLE;
    else if (done) begin
      state_n = other_valid ? (own0 ? OWN1 : OWN0) : IDLE;
      last_n = own1;
    end else if (!cur_valid)
      state_n = IDLE;
    else
      wd_n = wd == WDW'(TIMEOUT) ? wd : wd + WDW'(1);
  end
  // datapath mux toward the slave and completion routing back to the owner
  always_comb begin
    grant = {own1, own0};
    mem_valid = cur_valid & ~abort;
    mem_instr = own0 ? m0_mem_instr : own1 ? m1_mem_instr : 1'b0;
    mem_addr = own0 ? m0_mem_addr : own1 ? m1_mem_addr : '0;
    mem_wdata = own0 ? m0_mem_wdata : own1 ? m1_mem_wdata : '0;
    mem_wstrb = own0 ? m0_mem_wstrb : own1 ? m1_mem_wstrb : '0;
    m0_mem_ready = own0 & done;
    m1_mem_ready = own1 & done;
    m0_mem_rdata = own0 ? (abort ? TIMEOUT_RDATA : mem_rdata) : '0;
    m1_mem_rdata = own1 ? (abort ? TIMEOUT_RDATA : mem_rdata) : '0;
  end
endmodule
